// File: rtl/executor_clear.sv
// Line-clear executor: scans the playfield bottom-up, compacts surviving rows downward
// and zero-fills the rows vacated at the top, reporting how many full rows were removed.
module executor_clear #(
    parameter  int width_p  = 16,
    parameter  int height_p = 32,
    localparam int aw       = $clog2(height_p),
    localparam int cw       = $clog2(height_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic               done_o,
    output logic [cw-1:0]      cleared_cnt_o,
    output logic [aw-1:0]      mm_read_addr_o,
    input  logic [width_p-1:0] mm_read_data_i,
    output logic [aw-1:0]      mm_write_addr_o,
    output logic [width_p-1:0] mm_write_data_o,
    output logic               mm_write_v_o
);

    typedef enum logic [1:0] {
        eIDLE = 2'd0,
        eScan = 2'd1,
        eFill = 2'd2,
        eDone = 2'd3
    } state_e;

    localparam logic [aw-1:0] last_row_c = aw'(height_p - 1);
    localparam logic [aw-1:0] zero_row_c = {aw{1'b0}};
    localparam logic [cw-1:0] zero_cnt_c = {cw{1'b0}};

    state_e        state_r, state_s;
    logic [aw-1:0] rp_r, rp_s;
    logic [aw-1:0] wp_r, wp_s;
    logic [cw-1:0] cnt_r, cnt_s;
    logic          full_s;

    assign full_s = &mm_read_data_i;

    // State and datapath registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= eIDLE;
            rp_r    <= last_row_c;
            wp_r    <= last_row_c;
            cnt_r   <= zero_cnt_c;
        end else begin
            state_r <= state_s;
            rp_r    <= rp_s;
            wp_r    <= wp_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state, pointer updates and memory-port outputs
    always_comb begin
        state_s         = state_r;
        rp_s            = rp_r;
        wp_s            = wp_r;
        cnt_s           = cnt_r;
        ready_o         = 1'b0;
        done_o          = 1'b0;
        mm_read_addr_o  = last_row_c;
        mm_write_addr_o = wp_r;
        mm_write_data_o = {width_p{1'b0}};
        mm_write_v_o    = 1'b0;
        case (state_r)
            eIDLE: begin
                ready_o = 1'b1;
                rp_s    = last_row_c;
                wp_s    = last_row_c;
                if (v_i) begin
                    cnt_s   = zero_cnt_c;
                    state_s = eScan;
                end else begin
                    state_s = eIDLE;
                end
            end
            eScan: begin
                mm_read_addr_o = rp_r;
                rp_s = (rp_r == zero_row_c) ? rp_r : rp_r - aw'(1);
                if (full_s) begin
                    cnt_s = cnt_r + cw'(1);
                end else begin
                    wp_s = (wp_r == zero_row_c) ? wp_r : wp_r - aw'(1);
                    // A row that would land on itself needs no rewrite
                    if (rp_r != wp_r) begin
                        mm_write_v_o    = 1'b1;
                        mm_write_data_o = mm_read_data_i;
                    end else begin
                        mm_write_v_o    = 1'b0;
                    end
                end
                if (rp_r == zero_row_c) begin
                    state_s = (cnt_s != zero_cnt_c) ? eFill : eDone;
                end else begin
                    state_s = eScan;
                end
            end
            eFill: begin
                mm_write_v_o = 1'b1;
                if (wp_r == zero_row_c) begin
                    state_s = eDone;
                end else begin
                    wp_s    = wp_r - aw'(1);
                    state_s = eFill;
                end
            end
            eDone: begin
                done_o  = 1'b1;
                state_s = eIDLE;
            end
            default: begin
                state_s = eIDLE;
            end
        endcase
    end

    // The running count stays hidden while a pass is in flight
    assign cleared_cnt_o = ((state_r == eScan) || (state_r == eFill)) ? zero_cnt_c : cnt_r;

endmodule
